// File: rtl/mux2_1_byte_packer.sv
// Purpose : packs four consecutive 2-bit mux symbols into one byte on a valid/ready output.
// Latency : a byte appears on data_out/valid_out the cycle after the edge accepting its 4th symbol.
// Backpressure: in_ready drops only when a byte would complete into a full, non-draining output register.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   data_in/valid_in        upstream symbol and its qualifier
//   in_ready                combinational accept indication to upstream
//   data_out/valid_out      packed byte and its qualifier
//   out_ready               downstream consume strobe
//   fill_level              symbols currently held in the accumulator (0..3)
module mux2_1_byte_packer #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] data_in,
    input  logic       valid_in,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       out_ready,
    output logic [1:0] fill_level
);

    // Slot k of acc always lives at acc[2k+1:2k]; the bit order of the
    // finished byte is decided only when the byte is assembled.
    logic [5:0] acc;
    logic [1:0] cnt;
    logic       accept;
    logic       complete;
    logic [7:0] byte_full;

    // Only a completing symbol needs room in the output register, so
    // partial-byte symbols keep flowing even while the output is stalled.
    assign in_ready   = !((cnt == 2'd3) && valid_out && !out_ready);
    assign accept     = valid_in && in_ready;
    assign complete   = accept && (cnt == 2'd3);
    assign fill_level = cnt;

    always_comb begin
        byte_full = 8'h00;
        if (LSB_FIRST != 0) begin
            byte_full = {data_in, acc};
        end else begin
            byte_full = {acc[1:0], acc[3:2], acc[5:4], data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= 6'd0;
            cnt       <= 2'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            if (accept && !complete) begin
                case (cnt)
                    2'd0:    acc[1:0] <= data_in;
                    2'd1:    acc[3:2] <= data_in;
                    2'd2:    acc[5:4] <= data_in;
                    default: ;
                endcase
                cnt <= cnt + 2'd1;
            end

            // A completing byte overrides a same-cycle drain, so a
            // drain+load keeps valid_out high with no bubble.
            if (complete) begin
                data_out  <= byte_full;
                valid_out <= 1'b1;
                acc       <= 6'd0;
                cnt       <= 2'd0;
            end else if (valid_out && out_ready) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule
